i2c_tmp101_responder: RTL
=========================

// Module: i2c_tmp101_responder
// PURPOSE
//  I2C slave that emulates a TMP101 sensor on the board's SCL/SDA pins: the far end of the
//  TMP101 read master. Decodes START/STOP, matches a 7-bit address, ACKs, returns a 16-bit
//  temperature MSB-first on reads, and accepts pointer/config bytes on writes.
//  Oversamples the bus with the system clock. Used as bench target and loopback partner.
// PARAMETERS
//  SLAVE_ADDRESS  7'b1001000  7-bit I2C address answered (TMP101 ADD0 = 0)
//  SYNC_STAGES    2           synchronizer flops on SCL and SDA inputs (>= 2)
// PORTS
//  clock        in     1   system clock; must be >= 16x SCL frequency
//  Reset        in     1   asynchronous, active-low reset
//  SCL          in     1   I2C clock from master (never driven; no clock stretching)
//  SDA          inout  1   open-drain data: drives 1'b0 or 1'bz only, never 1'b1
//  Temperature  in     16  TMP101 register value {MSB, LSB}, returned on reads
//  Pointer      out    2   pointer register (first byte of a write transaction)
//  ConfigReg    out    8   config byte (written when Pointer == 2'b01)
//  Selected     out    1   high from address match until STOP/START/NACK
//  ByteDone     out    1   one-cycle pulse per completed data byte (either direction)
// BEHAVIOUR
//  - Reset (Reset low): SDA released (z), Pointer=0, ConfigReg=0, Selected=0, ByteDone=0,
//    state IDLE; effective immediately, including mid-byte.
//  - SCL/SDA pass through SYNC_STAGES flops, plus one history flop for edge detection.
//    All decisions use synchronized values; latency pin->action = SYNC_STAGES+1 clocks.
//  - START: SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high. Either one, in any
//    state, releases SDA, clears Selected and bit count; START -> ADDR, STOP -> IDLE.
//    Repeated START is a START.
//  - Data sampled on SCL rising edge; SDA output changes only on SCL falling edge.
//  - States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
//  - ADDR: shift 8 bits (7 addr + R/W). After 8th rising edge: match -> ADDR_ACK,
//    Selected=1, Temperature snapshot into 16-bit TX buffer (no tearing); mismatch ->
//    WAIT_STOP with SDA released (no ACK).
//  - ADDR_ACK: drive SDA low at the falling edge after bit 8, release at the 9th falling
//    edge. R/W=0 -> WR_BYTE; R/W=1 -> RD_BYTE with TX buffer MSB driven on that same edge.
//  - WR_BYTE: shift 8 bits; first byte of the transaction -> Pointer <= byte[1:0];
//    later bytes -> ConfigReg if Pointer==01, else discarded. ByteDone pulses once, then
//    WR_ACK (ACK driven exactly as in ADDR_ACK) -> WR_BYTE. All write bytes are ACKed.
//  - RD_BYTE: drive '0' bits low, release for '1' bits, one bit per falling edge; release
//    SDA at the falling edge after bit 8, ByteDone pulse, -> RD_ACK.
//  - RD_ACK: sample master at 9th rising edge: ACK(0) -> RD_BYTE with the next byte
//    (MSB, LSB, MSB, LSB... wrap); NACK(1) -> WAIT_STOP, Selected=0.
//  - WAIT_STOP: SDA released, ignore bits until STOP/START.
//  - Read data is Temperature regardless of Pointer (emulator simplification).
//  - SCL edges and START/STOP in the same clock: START/STOP wins (only possible if
//    SDA and SCL toggle together; treated as protocol error, bus released).
// TESTING
//  1 Reset low mid-RD_BYTE -> SDA z within 1 clock, Selected=0, Pointer=0, ConfigReg=0.
//  2 START, addr 0x91 (0x48 read), Temperature=16'h1A40, master ACK then NACK, STOP ->
//    slave ACKs addr, SDA shows 0x1A then 0x40, two ByteDone pulses, ends IDLE.
//  3 START, addr 0x92 (0x49 write) -> no ACK (SDA z at 9th clock), Selected stays 0.
//  4 START, 0x90, 0x01, 0x60, STOP -> three ACKs, Pointer=01, ConfigReg=8'h60.
//  5 Read with Temperature changing to 16'hFFFF mid-transfer -> bytes still from the
//    snapshot taken at address match; 3 ACKed reads return MSB, LSB, MSB.
//  6 Repeated START during WR_BYTE, then 0x91 -> write aborted, read proceeds normally.

Source files
------------

// File: rtl/i2c_tmp101_responder_if.sv
// Open-drain I2C bus between a master and the TMP101 responder.
// SDA idles high through the tri1 pull-up; each side may only pull it low.
interface i2c_tmp101_responder_if;
  logic SCL;
  logic masterSdaLow;
  tri1  SDA;

  assign SDA = masterSdaLow ? 1'b0 : 1'bz;

  modport slave  (input SCL, inout SDA);
  modport master (output SCL, output masterSdaLow, input SDA);
endinterface

// File: rtl/i2c_tmp101_responder.sv
// I2C slave emulating a TMP101: oversamples SCL/SDA, ACKs its address, returns a
// snapshot of Temperature MSB-first on reads and stores pointer/config bytes on writes.
module i2c_tmp101_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'b1001000,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                   clock,
  input  logic                   Reset,
  i2c_tmp101_responder_if.slave  bus,
  input  logic [15:0]            Temperature,
  output logic [1:0]             Pointer,
  output logic [7:0]             ConfigReg,
  output logic                   Selected,
  output logic                   ByteDone
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } stateT;

  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic sclPrev, sdaPrev;
  logic sclNow, sdaNow;
  logic sclRise, sclFall, startDet, stopDet;

  stateT       state, stateNext;
  logic [3:0]  bitCount, bitCountNext;
  logic [7:0]  shiftReg, shiftRegNext;
  logic [15:0] txBuf, txBufNext;
  logic        byteSel, byteSelNext;
  logic        rwBit, rwBitNext;
  logic        firstWrite, firstWriteNext;
  logic        ackOn, ackOnNext;
  logic        gotAck, gotAckNext;
  logic        sdaLow, sdaLowNext;
  logic [1:0]  pointerNext;
  logic [7:0]  configNext;
  logic        selectedNext, byteDoneNext;

  logic [7:0]  rxByte, currentByte;
  logic [2:0]  txIdx;
  logic        nextMsb;

  // Bus idles high, so the synchronizer and history flops reset to 1 to avoid
  // a phantom START/STOP when reset is released.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], bus.SCL};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], bus.SDA};
      sclPrev <= sclSync[SYNC_STAGES-1];
      sdaPrev <= sdaSync[SYNC_STAGES-1];
    end
  end

  assign sclNow   = sclSync[SYNC_STAGES-1];
  assign sdaNow   = sdaSync[SYNC_STAGES-1];
  assign sclRise  = sclNow & ~sclPrev;
  assign sclFall  = ~sclNow & sclPrev;
  assign startDet = sclNow & sdaPrev & ~sdaNow;
  assign stopDet  = sclNow & ~sdaPrev & sdaNow;

  assign rxByte      = {shiftReg[6:0], sdaNow};
  assign currentByte = byteSel ? txBuf[7:0] : txBuf[15:8];
  assign nextMsb     = byteSel ? txBuf[15] : txBuf[7];
  assign txIdx       = 3'd7 - bitCount[2:0];

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      bitCount   <= '0;
      shiftReg   <= '0;
      txBuf      <= '0;
      byteSel    <= 1'b0;
      rwBit      <= 1'b0;
      firstWrite <= 1'b0;
      ackOn      <= 1'b0;
      gotAck     <= 1'b0;
      sdaLow     <= 1'b0;
      Pointer    <= '0;
      ConfigReg  <= '0;
      Selected   <= 1'b0;
      ByteDone   <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCount   <= bitCountNext;
      shiftReg   <= shiftRegNext;
      txBuf      <= txBufNext;
      byteSel    <= byteSelNext;
      rwBit      <= rwBitNext;
      firstWrite <= firstWriteNext;
      ackOn      <= ackOnNext;
      gotAck     <= gotAckNext;
      sdaLow     <= sdaLowNext;
      Pointer    <= pointerNext;
      ConfigReg  <= configNext;
      Selected   <= selectedNext;
      ByteDone   <= byteDoneNext;
    end
  end

  always_comb begin
    stateNext      = state;
    bitCountNext   = bitCount;
    shiftRegNext   = shiftReg;
    txBufNext      = txBuf;
    byteSelNext    = byteSel;
    rwBitNext      = rwBit;
    firstWriteNext = firstWrite;
    ackOnNext      = ackOn;
    gotAckNext     = gotAck;
    sdaLowNext     = sdaLow;
    pointerNext    = Pointer;
    configNext     = ConfigReg;
    selectedNext   = Selected;
    byteDoneNext   = 1'b0;

    case (state)
      IDLE, WAIT_STOP: sdaLowNext = 1'b0;

      ADDR: begin
        if (sclRise) begin
          shiftRegNext = rxByte;
          bitCountNext = bitCount + 4'd1;
          if (bitCount == 4'd7) begin
            bitCountNext = '0;
            if (rxByte[7:1] == SLAVE_ADDRESS) begin
              stateNext      = ADDR_ACK;
              selectedNext   = 1'b1;
              txBufNext      = Temperature;
              byteSelNext    = 1'b0;
              rwBitNext      = rxByte[0];
              firstWriteNext = 1'b1;
              ackOnNext      = 1'b0;
            end else begin
              stateNext = WAIT_STOP;
            end
          end
        end
      end

      // First falling edge pulls SDA low for the ACK, the next one ends it.
      ADDR_ACK, WR_ACK: begin
        if (sclFall) begin
          if (!ackOn) begin
            sdaLowNext = 1'b1;
            ackOnNext  = 1'b1;
          end else begin
            ackOnNext    = 1'b0;
            bitCountNext = '0;
            if (state == ADDR_ACK && rwBit) begin
              stateNext  = RD_BYTE;
              sdaLowNext = ~currentByte[7];
            end else begin
              stateNext  = WR_BYTE;
              sdaLowNext = 1'b0;
            end
          end
        end
      end

      WR_BYTE: begin
        if (sclRise) begin
          shiftRegNext = rxByte;
          bitCountNext = bitCount + 4'd1;
          if (bitCount == 4'd7) begin
            bitCountNext = '0;
            byteDoneNext = 1'b1;
            stateNext    = WR_ACK;
            ackOnNext    = 1'b0;
            if (firstWrite) begin
              pointerNext    = rxByte[1:0];
              firstWriteNext = 1'b0;
            end else if (Pointer == 2'b01) begin
              configNext = rxByte;
            end
          end
        end
      end

      // The MSB was already driven on entry; each rise counts a bit the master took.
      RD_BYTE: begin
        if (sclRise && bitCount != 4'd8) begin
          bitCountNext = bitCount + 4'd1;
        end
        if (sclFall) begin
          if (bitCount == 4'd8) begin
            sdaLowNext   = 1'b0;
            byteDoneNext = 1'b1;
            stateNext    = RD_ACK;
            gotAckNext   = 1'b0;
            bitCountNext = '0;
          end else begin
            sdaLowNext = ~currentByte[txIdx];
          end
        end
      end

      RD_ACK: begin
        if (sclRise) begin
          if (!sdaNow) begin
            gotAckNext = 1'b1;
          end else begin
            stateNext    = WAIT_STOP;
            selectedNext = 1'b0;
          end
        end
        if (sclFall && gotAck) begin
          gotAckNext   = 1'b0;
          byteSelNext  = ~byteSel;
          sdaLowNext   = ~nextMsb;
          stateNext    = RD_BYTE;
          bitCountNext = '0;
        end
      end

      default: stateNext = IDLE;
    endcase

    // A bus condition overrides whatever the byte machinery wanted this cycle.
    if (startDet || stopDet) begin
      sdaLowNext   = 1'b0;
      selectedNext = 1'b0;
      bitCountNext = '0;
      byteDoneNext = 1'b0;
      ackOnNext    = 1'b0;
      gotAckNext   = 1'b0;
      stateNext    = startDet ? ADDR : IDLE;
    end
  end

  assign bus.SDA = sdaLow ? 1'b0 : 1'bz;

endmodule
